// File: rtl/ram_program_loader.sv
// ram_program_loader
//   Writes a stream of program bytes into the CPU's read-only program RAM,
//   starting at address 0. It then reads the whole RAM back and compares an
//   8-bit running sum with the sum of the accepted bytes. The CPU is held in
//   clear (cpu_hold, ORed into the CPU clr) while a session is in progress,
//   and stays held if the readback does not match.
//
// Ports
//   clk        system clock, rising edge
//   clr        synchronous active-high reset
//   start      begin a load session (taken in IDLE, DONE or ERROR only)
//   in_data    program byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle (LOAD only)
//   ram_we     RAM write strobe, same cycle as byte acceptance
//   ram_ce     RAM read enable during readback
//   ram_addr   RAM address, 0 whenever no strobe is active
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, combinational from ram_addr
//   cpu_hold   keep the CPU in clear
//   busy       LOAD or VERIFY in progress
//   done       last session loaded and verified
//   err        last session failed verification
//   count      bytes accepted in the current session (0..DEPTH)
//   checksum   sum of accepted bytes, modulo 2**DATA_W
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset, strobes off, CPU free
// LOAD   | accepting bytes, one RAM write per accepted byte
// VERIFY | reading every RAM word back, accumulating the readback sum
// DONE   | image verified, CPU released, done held
// ERROR  | readback mismatch, CPU kept in clear, err held

module ram_program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic              ram_ce,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W:0]   count_n;
  logic [DATA_W-1:0] checksum_n;
  logic [DATA_W-1:0] rsum, rsum_n;
  logic [DATA_W-1:0] rsum_total;
  logic              done_n, err_n;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      addr     <= '0;
      count    <= '0;
      checksum <= '0;
      rsum     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      count    <= count_n;
      checksum <= checksum_n;
      rsum     <= rsum_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    count_n    = count;
    checksum_n = checksum;
    rsum_n     = rsum;
    done_n     = done;
    err_n      = err;
    rsum_total = rsum + ram_rdata;

    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_ce    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    cpu_hold  = 1'b0;
    busy      = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        // A failed image must never run, so ERROR keeps the CPU held.
        cpu_hold = (state == S_ERROR);
        if (start) begin
          state_n    = S_LOAD;
          addr_n     = '0;
          count_n    = '0;
          checksum_n = '0;
          rsum_n     = '0;
          done_n     = 1'b0;
          err_n      = 1'b0;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          // Write lands on the same edge the byte is accepted.
          ram_we     = 1'b1;
          ram_addr   = addr;
          ram_wdata  = in_data;
          addr_n     = addr + ADDR_W'(1);
          count_n    = count + (ADDR_W + 1)'(1);
          checksum_n = checksum + in_data;
          if (addr == LAST_ADDR) begin
            // addr wraps to 0 here, ready for the readback pass.
            state_n = S_VERIFY;
            rsum_n  = '0;
          end
        end
      end

      S_VERIFY: begin
        ram_ce   = 1'b1;
        ram_addr = addr;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        rsum_n   = rsum_total;
        addr_n   = addr + ADDR_W'(1);
        if (addr == LAST_ADDR) begin
          // Compare including the last word read this cycle.
          if (rsum_total == checksum) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_ERROR;
            err_n   = 1'b1;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/ram_program_loader.md
Name: ram_program_loader

Overview:
- Writer-side counterpart to the processor's read-only program RAM, which the CPU fetch path only reads.
- Accepts a stream of program bytes over a valid/ready byte interface and writes them into consecutive RAM addresses starting at 0.
- Reads the whole RAM back and checks an 8-bit checksum.
- Holds the CPU in clear for the entire load. Sits beside the RAM at the top level; its cpu_hold output is ORed into the CPU clr.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word / byte-stream width.
- DEPTH, 16, number of words loaded per session; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  synchronous active-high reset.
- start  input  1  begin a load session; sampled only in IDLE, DONE or ERROR.
- in_data  input  DATA_W  program byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- ram_we  output  1  RAM write strobe.
- ram_ce  output  1  RAM read enable, used during readback.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  RAM read data, combinational from ram_addr when ram_ce=1.
- cpu_hold  output  1  keep CPU in clear.
- busy  output  1  session in progress.
- done  output  1  last session loaded and verified.
- err  output  1  last session failed verification.
- count  output  ADDR_W+1  bytes accepted in current session (0..DEPTH).
- checksum  output  DATA_W  modulo-2^DATA_W sum of accepted bytes.

Behaviour:
- Clock ports are clk and clr, matching the codebase convention. Reset is synchronous and active-high.
- clr=1 at a rising edge has priority over everything, including mid-LOAD and mid-VERIFY:
  - state goes to IDLE;
  - addr, count, checksum and readback sum go to 0;
  - done=0, err=0.
  - The next cycle shows in_ready=0, ram_we=0, ram_ce=0, cpu_hold=0, busy=0.
- FSM states: IDLE, LOAD, VERIFY, DONE, ERROR.
- IDLE:
  - All strobes 0; cpu_hold=0.
  - start=1 -> LOAD with addr=0, count=0, checksum=0, done=0, err=0.
- LOAD:
  - in_ready=1, cpu_hold=1, busy=1.
  - Transfer occurs when in_valid&in_ready at a clock edge.
  - ram_we = in_valid & in_ready (combinational), ram_addr=addr, ram_wdata=in_data. The write lands at the same edge as acceptance: zero latency, one byte per cycle maximum.
  - On transfer: addr+1, count+1, checksum += in_data (wraps modulo 256).
  - in_valid=0 stalls indefinitely; no timeout.
  - Transfer at addr=DEPTH-1 -> VERIFY. On the same edge addr wraps to 0 and rsum=0; count=DEPTH.
- VERIFY:
  - in_ready=0, ram_we=0, ram_ce=1, ram_addr=addr, cpu_hold=1, busy=1.
  - Each cycle: rsum += ram_rdata, addr+1. Takes exactly DEPTH cycles.
  - On the cycle with addr=DEPTH-1, the comparison uses (rsum + ram_rdata) against checksum:
    - equal -> DONE, done=1;
    - unequal -> ERROR, err=1.
- DONE:
  - cpu_hold=0, busy=0, done=1 held.
  - start=1 -> new session (LOAD, done cleared).
- ERROR:
  - cpu_hold=1 held (CPU never runs a bad image), err=1 held.
  - start=1 -> LOAD, err cleared.
- start in LOAD/VERIFY is ignored.
- in_valid outside LOAD is ignored; nothing is written.
- ram_we and ram_ce are never both 1.
- ram_addr=0 whenever neither strobe is active.
- Total session latency from start edge to done: DEPTH transfer cycles (at full rate) + DEPTH verify cycles + 1.

Test Plan:
- Reset, then start, then stream bytes 0x10..0x1F back-to-back with in_valid=1 -> 16 writes to addr 0..15 on consecutive cycles, checksum=0x78, count=16, 16 VERIFY cycles with ram_ce=1, then done=1, cpu_hold=0. Total 33 cycles after start.
- Same stream with in_valid deasserted for 3 cycles after byte 5 -> no ram_we during the gap, addr holds at 6, the final result is identical (checksum 0x78, done=1).
- Load all 0xFF -> checksum wraps to 0xF0. Bench model corrupts RAM word 7 to 0x00 before readback -> err=1, done=0, cpu_hold stays 1. Then start plus a clean reload -> err=0, done=1.
- Assert clr during LOAD after 9 bytes -> next cycle IDLE, count=0, checksum=0, in_ready=0, cpu_hold=0. Start plus a full 16-byte load -> done=1.
- Pulse start during LOAD (byte 4) and during VERIFY -> no restart, count continues 5, 6, ..., session completes normally.
- in_valid=1 with in_data=0xAA while in IDLE and DONE -> ram_we never asserts, count/checksum unchanged.
